// File: rtl/key_responder.sv
// key_responder: req/ack key acceptor with programmable ack delay, key-sequence check and log FIFO
module key_responder #(
  parameter int DELAY = 2,
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [3:0] req_key,
  output logic       ack,
  output logic       out_valid,
  output logic [3:0] out_key,
  input  logic       out_ready,
  output logic       seq_err,
  output logic [7:0] xfer_count
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
  state_t state;
  logic [3:0] cnt;
  logic [3:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] used;
  logic first;
  logic [3:0] prev;
  logic push, pop, full;
  assign full = used == (AW+1)'(DEPTH);
  assign push = state == ACK && req;
  assign pop = out_valid && out_ready;
  assign ack = state == ACK;
  assign out_valid = used != '0;
  assign out_key = mem[rp];
  always_ff @(posedge clk)
    if (push) mem[wp] <= req_key;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      wp <= '0;
      rp <= '0;
      used <= '0;
      seq_err <= 1'b0;
      xfer_count <= '0;
      first <= 1'b1;
      prev <= '0;
    end else begin
      if (state == IDLE && req && !full) begin
        state <= DELAY == 0 ? ACK : WAIT;
        cnt <= 4'(DELAY);
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
        if (cnt == 4'd1) state <= ACK;
      end else if (state == ACK) begin
        state <= IDLE;
      end
      if (push) begin
        wp <= wp + 1'b1;
        xfer_count <= xfer_count + 8'd1;
        prev <= req_key;
        first <= 1'b0;
        if (!first && req_key != prev + 4'd1) seq_err <= 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      used <= used + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: tb/tb_key_responder.sv
// tb_key_responder: directed checks of key_responder with DELAY=2 and DELAY=0 instances
module tb_key_responder;
  logic clk = 1'b0, rst = 1'b1;
  logic req = 0, rdy = 0, ack, ov, se;
  logic [3:0] key = 0, ok;
  logic [7:0] xc;
  logic req0 = 0, rdy0 = 0, ack0, ov0, se0;
  logic [3:0] key0 = 0, ok0;
  logic [7:0] xc0;
  int n = 0, errs = 0;
  always #5 clk = ~clk;
  key_responder #(.DELAY(2), .DEPTH(4)) d (.clk(clk), .rst(rst), .req(req), .req_key(key), .ack(ack),
    .out_valid(ov), .out_key(ok), .out_ready(rdy), .seq_err(se), .xfer_count(xc));
  key_responder #(.DELAY(0), .DEPTH(4)) z (.clk(clk), .rst(rst), .req(req0), .req_key(key0), .ack(ack0),
    .out_valid(ov0), .out_key(ok0), .out_ready(rdy0), .seq_err(se0), .xfer_count(xc0));
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic xfer(input logic [3:0] k);
    key = k;
    req = 1;
    repeat (3) tick;
    chk("xfer_ack_hi", 8'(ack), 8'd1);
    tick;
    chk("xfer_ack_lo", 8'(ack), 8'd0);
  endtask
  initial begin
    repeat (2) tick;
    rst = 0;
    chk("rst_ack", 8'(ack), 8'd0);
    chk("rst_ov", 8'(ov), 8'd0);
    chk("rst_se", 8'(se), 8'd0);
    chk("rst_xc", xc, 8'd0);
    chk("rst_xc0", xc0, 8'd0);
    // DELAY=0: ack every second cycle, keys drained in order as they arrive
    req0 = 1; rdy0 = 1; key0 = 1;
    tick; chk("d0_ack1", 8'(ack0), 8'd1);
    tick; chk("d0_gap1", 8'(ack0), 8'd0); chk("d0_key1", 8'(ok0), 8'd1); chk("d0_xc1", xc0, 8'd1);
    key0 = 2;
    tick; chk("d0_ack2", 8'(ack0), 8'd1); chk("d0_pop1", 8'(ov0), 8'd0);
    tick; chk("d0_key2", 8'(ok0), 8'd2);
    key0 = 3;
    tick; chk("d0_ack3", 8'(ack0), 8'd1);
    tick; chk("d0_key3", 8'(ok0), 8'd3); chk("d0_xc3", xc0, 8'd3); chk("d0_se", 8'(se0), 8'd0);
    req0 = 0;
    tick; chk("d0_empty", 8'(ov0), 8'd0);
    // DELAY=2: ack only in cycle 3 after req rises
    req = 1; key = 5;
    tick; chk("dl_c1", 8'(ack), 8'd0);
    tick; chk("dl_c2", 8'(ack), 8'd0);
    tick; chk("dl_c3", 8'(ack), 8'd1); chk("dl_noxfer", xc, 8'd0);
    tick; chk("dl_c4", 8'(ack), 8'd0); chk("dl_xc", xc, 8'd1); chk("dl_key", 8'(ok), 8'd5);
    xfer(6); chk("seq_6", 8'(se), 8'd0);
    xfer(8); chk("seq_8", 8'(se), 8'd1); chk("xc_3", xc, 8'd3);
    xfer(9); chk("seq_9", 8'(se), 8'd1); chk("xc_4", xc, 8'd4);
    // FIFO full: req held, no ack
    key = 10;
    repeat (6) begin tick; chk("full_hold", 8'(ack), 8'd0); end
    chk("full_xc", xc, 8'd4);
    rdy = 1;
    tick; rdy = 0; chk("pop_head", 8'(ok), 8'd6);
    tick; chk("resume1", 8'(ack), 8'd0);
    tick; chk("resume2", 8'(ack), 8'd0);
    tick; chk("resume_ack", 8'(ack), 8'd1);
    tick; chk("xc_5", xc, 8'd5); chk("seq_10", 8'(se), 8'd1);
    req = 0; rdy = 1;
    chk("ord_6", 8'(ok), 8'd6);
    tick; chk("ord_8", 8'(ok), 8'd8);
    tick; chk("ord_9", 8'(ok), 8'd9);
    tick; chk("ord_10", 8'(ok), 8'd10);
    tick; chk("drained", 8'(ov), 8'd0);
    rdy = 0;
    // req withdrawn during ACK: nothing transferred
    req = 1; key = 11;
    repeat (3) tick;
    chk("drop_ack", 8'(ack), 8'd1);
    req = 0;
    tick; chk("drop_ack_lo", 8'(ack), 8'd0); chk("drop_ov", 8'(ov), 8'd0); chk("drop_xc", xc, 8'd5);
    tick; chk("drop_idle", 8'(ack), 8'd0);
    // reset mid-WAIT with two entries logged
    xfer(11); xfer(12);
    chk("pre_rst_xc", xc, 8'd7);
    key = 13;
    tick; chk("in_wait", 8'(ack), 8'd0);
    rst = 1;
    tick;
    rst = 0;
    chk("r2_ack", 8'(ack), 8'd0);
    chk("r2_ov", 8'(ov), 8'd0);
    chk("r2_xc", xc, 8'd0);
    chk("r2_se", 8'(se), 8'd0);
    xfer(4'hE); chk("first_unchk", 8'(se), 8'd0); chk("r2_xc1", xc, 8'd1);
    xfer(4'hF); chk("seq_F", 8'(se), 8'd0);
    xfer(4'h0); chk("seq_wrap", 8'(se), 8'd0); chk("r2_xc3", xc, 8'd3);
    chk("r2_head", 8'(ok), 8'hE);
    req = 0;
    tick;
    $display("== %0d vectors applied, %0d miscompares ==", n, errs);
    $finish;
  end
endmodule
